// File: rtl/sdp_ram_reader.sv
// -----------------------------------------------------------------------------
// sdp_ram_reader
//
// Read-side controller for a simple dual-port, single-clock block RAM with a
// fixed one-cycle read latency. A transfer is started with a base address and
// a word count. The block issues RAM reads and returns the data as a
// valid/ready stream. Backpressure from the consumer is fully supported.
//
// Compile-time option:
//   SDP_RD_ABORT_EN : adds the 'abort' input, which flushes the transfer in
//                     progress and ends it with a done pulse.
//
// Ports:
//   clka       single clock, shared with the RAM
//   rst_n      asynchronous active-low reset
//   start      one-cycle request, sampled only while idle
//   base_addr  first read address (sampled with start)
//   len        number of words, 0..2**ASIZE (sampled with start)
//   abort      (SDP_RD_ABORT_EN only) cancel the running transfer
//   busy       transfer in progress (READ, DRAIN, FIN)
//   done       one-cycle pulse at the end of a transfer
//   ram_enb    RAM read enable
//   ram_addrb  RAM read address
//   ram_doutb  RAM read data, valid one cycle after ram_enb
//   m_data     stream data (registered)
//   m_valid    stream valid (registered)
//   m_ready    stream ready
// -----------------------------------------------------------------------------
module sdp_ram_reader #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 10
) (
    input  logic             clka,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ASIZE-1:0] base_addr,
    input  logic [ASIZE:0]   len,
`ifdef SDP_RD_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic             ram_enb,
    output logic [ASIZE-1:0] ram_addrb,
    input  logic [DSIZE-1:0] ram_doutb,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    localparam logic [ASIZE:0] CNT_ONE = (ASIZE+1)'(1);

    state_t           state_reg;
    logic [ASIZE-1:0] addr_reg;
    logic [ASIZE:0]   len_reg;
    logic [ASIZE:0]   issue_cnt_reg;
    logic [ASIZE:0]   accept_cnt_reg;
    logic             inflight_reg;

    // Two-entry output buffer: the output register plus one skid entry.
    logic [DSIZE-1:0] out_data_reg,  out_data_next;
    logic             out_valid_reg, out_valid_next;
    logic [DSIZE-1:0] skid_data_reg, skid_data_next;
    logic             skid_valid_reg, skid_valid_next;

    logic       abort_now;
    logic       pop;
    logic       push;
    logic [1:0] fill_level;
    logic       rd_issue;

`ifdef SDP_RD_ABORT_EN
    assign abort_now = abort && ((state_reg == READ) || (state_reg == DRAIN));
`else
    assign abort_now = 1'b0;
`endif

    assign pop  = out_valid_reg && m_ready;
    // The word requested last cycle is on ram_doutb now; an abort drops it.
    assign push = inflight_reg && !abort_now;

    // Words held or on their way, minus the one leaving this cycle. Issuing
    // only while this is below 2 means a returning word always has a slot.
    // occupancy + in-flight never exceeds 2, and pop implies a held word, so
    // the 2-bit arithmetic neither overflows nor underflows.
    assign fill_level = 2'(out_valid_reg) + 2'(skid_valid_reg)
                      + 2'(inflight_reg) - 2'(pop);
    assign rd_issue   = (state_reg == READ) && !abort_now && (fill_level < 2'd2);

    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == FIN);
    assign ram_enb   = rd_issue;
    assign ram_addrb = addr_reg;
    assign m_data    = out_data_reg;
    assign m_valid   = out_valid_reg;

    // Buffer next-state: FIFO order, skid entry always drains first.
    always_comb begin
        out_data_next   = out_data_reg;
        out_valid_next  = out_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_valid_next = skid_valid_reg;
        if (abort_now) begin
            out_valid_next  = 1'b0;
            skid_valid_next = 1'b0;
        end else if (!out_valid_reg || pop) begin
            if (skid_valid_reg) begin
                out_data_next   = skid_data_reg;
                out_valid_next  = 1'b1;
                skid_valid_next = push;
                if (push) begin
                    skid_data_next = ram_doutb;
                end
            end else if (push) begin
                out_data_next  = ram_doutb;
                out_valid_next = 1'b1;
            end else begin
                out_valid_next = 1'b0;
            end
        end else if (push) begin
            // Output stalled: the skid entry is free thanks to the issue rule.
            skid_data_next  = ram_doutb;
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            out_data_reg   <= '0;
            out_valid_reg  <= 1'b0;
            skid_data_reg  <= '0;
            skid_valid_reg <= 1'b0;
        end else begin
            out_data_reg   <= out_data_next;
            out_valid_reg  <= out_valid_next;
            skid_data_reg  <= skid_data_next;
            skid_valid_reg <= skid_valid_next;
        end
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            len_reg        <= '0;
            issue_cnt_reg  <= '0;
            accept_cnt_reg <= '0;
            inflight_reg   <= 1'b0;
        end else begin
            inflight_reg <= rd_issue;
            if (rd_issue) begin
                addr_reg      <= addr_reg + 1'b1;   // wraps modulo 2**ASIZE
                issue_cnt_reg <= issue_cnt_reg + CNT_ONE;
            end
            if (pop) begin
                accept_cnt_reg <= accept_cnt_reg + CNT_ONE;
            end
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        len_reg        <= len;
                        addr_reg       <= base_addr;
                        issue_cnt_reg  <= '0;
                        accept_cnt_reg <= '0;
                        state_reg      <= (len == '0) ? FIN : READ;
                    end
                end
                READ: begin
                    if (abort_now) begin
                        state_reg <= FIN;
                    end else if (rd_issue && (issue_cnt_reg + CNT_ONE == len_reg)) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Every read has been issued; the final acceptance also
                    // implies nothing is left in flight.
                    if (abort_now) begin
                        state_reg <= FIN;
                    end else if (pop && (accept_cnt_reg + CNT_ONE == len_reg)) begin
                        state_reg <= FIN;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
